counter_ud_mod: RTL and testbench
=================================

# counter_ud_mod

Parametrised bidirectional modulo counter: the generalised successor of the 4-bit up/down counter. Adds a configurable width and modulus, synchronous parallel load, a wrap/saturate mode, an enable prescaler and a sticky overflow flag. It is the standard counting primitive for timers, address generators and event counters in the lab designs.

## Interface
- WIDTH, 4: counter width in bits.
- MOD, 16: modulus; Q counts over 0..MOD-1. Legal range 2 ≤ MOD ≤ 2^WIDTH.
- PRESCALE, 1: number of enabled cycles per count step. Must be ≥ 1; 1 means every enabled cycle.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; gates both the prescaler and the counter.
- DIR  in  1  count direction: 1 = up, 0 = down.
- LOAD  in  1  synchronous parallel load; has priority over EN.
- D  in  WIDTH  load value.
- SAT  in  1  mode select: 0 = wrap, 1 = saturate at the terminal value.
- CLR_OVF  in  1  synchronous clear of OVF.
- Q  out  WIDTH  count value (registered).
- CO  out  1  terminal-count strobe (combinational).
- OVF  out  1  sticky overflow/underflow flag (registered).

## Operation
- **Reset (RESET=0, asynchronous):** Q=0, OVF=0, prescaler count PS=0. CO evaluates to its combinational value; it is 0 unless EN=1, DIR=0 and tick=1.
- **Prescaler:** internal PS counts 0..PRESCALE-1 on every EN=1 cycle and wraps to 0.
  - tick = EN & (PS == PRESCALE-1).
  - PS holds while EN=0.
  - PRESCALE=1 makes tick = EN.
- **Terminal condition:** term = DIR ? (Q == MOD-1) : (Q == 0).
- **CO** = tick & term & ~LOAD. It is asserted during the cycle whose edge would wrap or saturate.
- **Per-edge priority:**
  1. LOAD=1:
     - Q ← (D ≥ MOD) ? MOD-1 : D, i.e. the load value is clamped.
     - PS ← 0.
     - OVF ← 0.
     - EN, DIR and CLR_OVF are ignored this cycle.
  2. Else if tick=1 and term=0: Q ← Q+1 (up) or Q−1 (down).
  3. Else if tick=1 and term=1:
     - Wrap (SAT=0): Q ← 0 (up) or MOD-1 (down).
     - Saturate (SAT=1): Q holds.
     - In both modes OVF ← 1.
  4. Else Q holds.
- **OVF:**
  - Set by case 3.
  - Cleared by CLR_OVF=1 when case 3 is not occurring. Set wins over clear on the same edge.
  - Also cleared by LOAD.
- **Mode and direction changes:** DIR and SAT are sampled every edge and take effect immediately; there is no pipeline. A DIR change mid-prescale keeps the current PS value.
- **Arithmetic:** all next-state arithmetic is WIDTH bits, unsigned. Q never leaves 0..MOD-1, including when MOD < 2^WIDTH.

## Timing
- Q latency: 1 clock edge after the qualifying inputs. With PRESCALE=N and EN held high, Q steps once every N edges.
- The first step after reset or LOAD occurs on the N-th enabled edge.
- CO is valid combinationally in the same cycle as the inputs. It is high for exactly one cycle per terminal step while EN is held, and it stays high across consecutive ticks in saturate mode while Q is pinned at the terminal value.
- OVF rises on the edge that performs the terminal step.
- RESET asserts asynchronously. Release is sampled at the next CLK edge; the first count can occur on the first edge after release.
- RESET asserted mid-count or mid-prescale clears Q, PS and OVF immediately.

## Test plan
- **Reset/up-wrap:** WIDTH=4, MOD=10, PRESCALE=1, SAT=0. Hold RESET=0 with EN=1, then release with DIR=1 → Q goes 0,1,…,9,0. CO is high only while Q=9; OVF goes high on the 9→0 edge.
- **Down-wrap plus sticky clear:** same configuration, DIR=0 from Q=2 → Q goes 2,1,0,9,8. CO is high only while Q=0. OVF stays 1 until CLR_OVF is pulsed, then reads 0.
- **Saturate:** SAT=1, DIR=1 from Q=8 → Q goes 8,9,9,9. CO is high every cycle at Q=9 and OVF=1. Then DIR=0 → Q goes 8,7.
- **Load priority and clamp:**
  - LOAD=1 with D=5, EN=1, DIR=1 → next Q=5, OVF=0, CO=0.
  - LOAD=1 with D=14 → Q=9.
  - LOAD and a terminal tick on the same edge → the load wins.
- **Prescaler:** PRESCALE=3, MOD=10, up from Q=0 with EN=1 → Q steps on edges 3, 6, 9. With EN dropped for 2 cycles mid-prescale, the step is delayed by exactly 2 cycles.
- **Async reset mid-operation:** RESET pulsed low between edges at Q=7, OVF=1 → Q=0 and OVF=0 before the next edge. Counting resumes from 0 after release.

Source files
------------

// File: rtl/counter_ud_mod.sv
// Parametrised up/down modulo counter with clamped parallel load, wrap or
// saturate mode, enable prescaler and a sticky overflow flag.
module counter_ud_mod #(
   parameter int WIDTH    = 4,
   parameter int MOD      = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             sat,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             ovf
);

   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

   logic [WIDTH-1:0] q_r, q_nxt_s;
   logic [PS_W-1:0]  ps_r, ps_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic             tick_s, term_s;

   // Prescaler tick, terminal detect and the terminal-count strobe.
   always_comb begin
      tick_s = en && (ps_r == PS_LAST);
      if (dir) begin
         term_s = (q_r == Q_MAX);
      end else begin
         term_s = (q_r == {WIDTH{1'b0}});
      end
      co = tick_s & term_s & ~load;
   end

   // Next-state selection: load first, then count, then terminal step.
   always_comb begin
      q_nxt_s   = q_r;
      ps_nxt_s  = ps_r;
      ovf_nxt_s = ovf_r;
      if (load) begin
         // Out-of-range load values clamp to the terminal value
         if ({1'b0, d} >= MOD_EXT) begin
            q_nxt_s = Q_MAX;
         end else begin
            q_nxt_s = d;
         end
         ps_nxt_s  = {PS_W{1'b0}};
         ovf_nxt_s = 1'b0;
      end else begin
         if (!en) begin
            ps_nxt_s = ps_r;
         end else if (tick_s) begin
            ps_nxt_s = {PS_W{1'b0}};
         end else begin
            ps_nxt_s = ps_r + PS_W'(1'b1);
         end

         if (tick_s && !term_s) begin
            if (dir) begin
               q_nxt_s = q_r + WIDTH'(1'b1);
            end else begin
               q_nxt_s = q_r - WIDTH'(1'b1);
            end
         end else if (tick_s && term_s) begin
            if (sat) begin
               q_nxt_s = q_r;
            end else if (dir) begin
               q_nxt_s = {WIDTH{1'b0}};
            end else begin
               q_nxt_s = Q_MAX;
            end
         end else begin
            q_nxt_s = q_r;
         end

         // A terminal step sets OVF even when a clear is requested
         if (tick_s && term_s) begin
            ovf_nxt_s = 1'b1;
         end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
         end else begin
            ovf_nxt_s = ovf_r;
         end
      end
   end

   // Counter, prescaler and overflow state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r   <= {WIDTH{1'b0}};
         ps_r  <= {PS_W{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         q_r   <= q_nxt_s;
         ps_r  <= ps_nxt_s;
         ovf_r <= ovf_nxt_s;
      end
   end

   assign q   = q_r;
   assign ovf = ovf_r;

endmodule

// File: tb/tb_counter_ud_mod.sv
// Bench for counter_ud_mod: two instances (prescale 1 and 3, modulus 10) share
// stimulus; a modulo-arithmetic model is compared every cycle.
module tb_counter_ud_mod;

   localparam int MODV = 10;

   logic       clk = 1'b0;
   logic       reset, en, dir, load, sat, clr_ovf;
   logic [3:0] d;
   logic [3:0] qa, qb;
   logic       coa, cob, ovfa, ovfb;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] ps;
      logic        ovf;
   } mstate_t;

   mstate_t ma, mb;

   counter_ud_mod #(.WIDTH(4), .MOD(MODV), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .d(d),
      .sat(sat), .clr_ovf(clr_ovf), .q(qa), .co(coa), .ovf(ovfa));

   counter_ud_mod #(.WIDTH(4), .MOD(MODV), .PRESCALE(3)) dut_b (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .d(d),
      .sat(sat), .clr_ovf(clr_ovf), .q(qb), .co(cob), .ovf(ovfb));

   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic bit m_tick(mstate_t s, int n);
      return en && (int'(s.ps) == n - 1);
   endfunction

   function automatic bit m_term(mstate_t s);
      return dir ? (int'(s.q) == MODV - 1) : (int'(s.q) == 0);
   endfunction

   function automatic bit m_co(mstate_t s, int n);
      return m_tick(s, n) && m_term(s) && !load;
   endfunction

   function automatic mstate_t mstep(mstate_t s, int n);
      mstate_t r = s;
      bit tk = m_tick(s, n);
      bit tm = m_term(s);
      if (load) begin
         r.q   = (int'(d) >= MODV) ? MODV - 1 : int'(d);
         r.ps  = 0;
         r.ovf = 1'b0;
      end else begin
         if (en) r.ps = (int'(s.ps) + 1) % n;
         if (tk) begin
            if (!(sat && tm))
               r.q = dir ? (int'(s.q) + 1) % MODV : (int'(s.q) + MODV - 1) % MODV;
         end
         if (tk && tm)   r.ovf = 1'b1;
         else if (clr_ovf) r.ovf = 1'b0;
      end
      return r;
   endfunction

   // Reference model state update
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= mstep(ma, 1);
         mb <= mstep(mb, 3);
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      chk("qa",   int'(qa),   int'(ma.q));
      chk("ovfa", int'(ovfa), int'(ma.ovf));
      chk("coa",  int'(coa),  int'(m_co(ma, 1)));
      chk("qb",   int'(qb),   int'(mb.q));
      chk("ovfb", int'(ovfb), int'(mb.ovf));
      chk("cob",  int'(cob),  int'(m_co(mb, 3)));
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; sat = 1'b0;
      clr_ovf = 1'b0; d = 4'd0;

      // Reset held, then up-count with wrap
      step(3);
      chk("rst_q", int'(qa), 0);
      chk("rst_ovf", int'(ovfa), 0);
      reset = 1'b1;
      step(9);
      chk("up_q9", int'(qa), 9);
      chk("up_co9", int'(coa), 1);
      chk("up_ovf_pre", int'(ovfa), 0);
      step(1);
      chk("up_wrap_q", int'(qa), 0);
      chk("up_wrap_ovf", int'(ovfa), 1);

      // Down wrap and sticky clear
      load = 1'b1; d = 4'd2;
      step(1);
      chk("ld2_q", int'(qa), 2);
      load = 1'b0; dir = 1'b0;
      step(2);
      chk("dn_q0", int'(qa), 0);
      chk("dn_co0", int'(coa), 1);
      step(1);
      chk("dn_wrap_q", int'(qa), 9);
      chk("dn_wrap_ovf", int'(ovfa), 1);
      step(1);
      chk("dn_q8", int'(qa), 8);
      en = 1'b0;
      step(3);
      chk("hold_q", int'(qa), 8);
      chk("sticky_ovf", int'(ovfa), 1);
      clr_ovf = 1'b1;
      step(1);
      chk("clr_ovf", int'(ovfa), 0);
      clr_ovf = 1'b0;

      // Saturate at 9, then count down
      load = 1'b1; d = 4'd8; sat = 1'b1; dir = 1'b1; en = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      chk("sat_q9", int'(qa), 9);
      step(2);
      chk("sat_hold", int'(qa), 9);
      chk("sat_co", int'(coa), 1);
      chk("sat_ovf", int'(ovfa), 1);
      dir = 1'b0;
      step(2);
      chk("sat_dn", int'(qa), 7);

      // Load priority and clamping
      sat = 1'b0; dir = 1'b1; load = 1'b1; d = 4'd5;
      step(1);
      chk("ld5_q", int'(qa), 5);
      chk("ld5_ovf", int'(ovfa), 0);
      d = 4'd14;
      step(1);
      chk("ld14_clamp", int'(qa), 9);
      d = 4'd3;
      #1;
      chk("ld_term_co", int'(coa), 0);
      step(1);
      chk("ld_wins", int'(qa), 3);
      d = 4'd10;
      step(1);
      chk("ld10_clamp", int'(qa), 9);

      // Prescaler by 3, with an enable gap mid-prescale
      d = 4'd0;
      step(1);
      load = 1'b0;
      step(2);
      chk("ps_e2", int'(qb), 0);
      step(1);
      chk("ps_e3", int'(qb), 1);
      step(3);
      chk("ps_e6", int'(qb), 2);
      step(1);
      en = 1'b0;
      step(2);
      en = 1'b1;
      step(1);
      chk("ps_gap_e10", int'(qb), 2);
      step(1);
      chk("ps_gap_e11", int'(qb), 3);

      // Asynchronous reset at Q=7 with OVF set
      load = 1'b1; d = 4'd9;
      step(1);
      load = 1'b0;
      step(1);
      chk("pre_rst_ovf", int'(ovfa), 1);
      step(7);
      chk("pre_rst_q", int'(qa), 7);
      reset = 1'b0;
      #1;
      chk("arst_q", int'(qa), 0);
      chk("arst_ovf", int'(ovfa), 0);
      chk("arst_qb", int'(qb), 0);
      step(1);
      reset = 1'b1;
      step(1);
      chk("resume_q", int'(qa), 1);
      chk("resume_qb", int'(qb), 0);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
